// File: rtl/boolfn_sweep_if.sv
// Handshake/data bundle between the function-configuration side and boolfn_sweep.
// master drives table loads and sweep requests; slave is the sweep engine.
interface boolfn_sweep_if #(
  parameter int N_IN = 4
);
  localparam int TT_W = 1 << N_IN;

  logic              tt_load;
  logic [TT_W-1:0]   tt_in;
  logic              start;
  logic              step;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   vec_out;
  logic              f_out;
  logic              f_valid;
  logic [N_IN:0]     ones_count;

  modport master (
    output tt_load, tt_in, start, step,
    input  busy, done, vec_out, f_out, f_valid, ones_count
  );

  modport slave (
    input  tt_load, tt_in, start, step,
    output busy, done, vec_out, f_out, f_valid, ones_count
  );
endinterface

// File: rtl/boolfn_sweep.sv
// Programmable N-input truth table that sweeps every input vector and counts minterms.
// Build option: BOOLFN_SWEEP_STEP_EN makes the sweep advance only on step=1 cycles.
module boolfn_sweep #(
  parameter int                     N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]   TT_RESET = 16'hDF03
) (
  input  logic          clk,
  input  logic          rst_n,
  boolfn_sweep_if.slave bus
);
  localparam int TT_W   = 1 << N_IN;
  localparam int IDX_W  = N_IN + 1;
  localparam int ONES_W = N_IN + 1;
  // Index carries one extra bit so the terminal compare never sees a wrapped value.
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TT_W - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state_q, state_d;
  logic [TT_W-1:0]     tt_q, tt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic                f_q, f_d;
  logic                fv_q, fv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                adv;

`ifdef BOOLFN_SWEEP_STEP_EN
  assign adv = bus.step;
`else
  // step has no effect in this build; the port stays for identical instantiation.
  assign adv = bus.step | 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SWEEP;
      SWEEP:   if (adv && idx_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for every registered output; nothing reaches the ports combinationally.
  always_comb begin
    tt_d   = tt_q;
    idx_d  = idx_q;
    ones_d = ones_q;
    vec_d  = vec_q;
    f_d    = f_q;
    fv_d   = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tt_load) tt_d = bus.tt_in;
        if (bus.start) begin
          busy_d = 1'b1;
          idx_d  = '0;
          ones_d = '0;
        end
      end
      SWEEP: begin
        if (adv) begin
          vec_d  = idx_q[N_IN-1:0];
          f_d    = tt_q[idx_q[N_IN-1:0]];
          fv_d   = 1'b1;
          ones_d = ones_q + ONES_W'(tt_q[idx_q[N_IN-1:0]]);
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q   <= TT_RESET;
      idx_q  <= '0;
      ones_q <= '0;
      vec_q  <= '0;
      f_q    <= 1'b0;
      fv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tt_q   <= tt_d;
      idx_q  <= idx_d;
      ones_q <= ones_d;
      vec_q  <= vec_d;
      f_q    <= f_d;
      fv_q   <= fv_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.vec_out    = vec_q;
  assign bus.f_out      = f_q;
  assign bus.f_valid    = fv_q;
  assign bus.ones_count = ones_q;
endmodule

// File: tb/tb_boolfn_sweep.sv
// Self-checking bench for boolfn_sweep: directed scenarios plus random truth tables
// checked against a bit-indexing / popcount model of the function.
module tb_boolfn_sweep;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  boolfn_sweep_if #(.N_IN(4)) bus ();
  boolfn_sweep_if #(.N_IN(3)) b3 ();

  boolfn_sweep #(.N_IN(4), .TT_RESET(16'hDF03)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  boolfn_sweep #(.N_IN(3), .TT_RESET(8'hFF)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  // {busy, done, f_valid, vec_out, f_out, ones_count}
  function automatic logic [12:0] obs();
    return {bus.busy, bus.done, bus.f_valid, bus.vec_out, bus.f_out, bus.ones_count};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 13'h0) begin
      errors++; $display("FAIL reset outputs got %h exp %h", obs(), 13'h0);
    end
    checks++;
    if ({b3.busy, b3.done, b3.f_valid, b3.vec_out, b3.f_out, b3.ones_count} !== 11'h0) begin
      errors++; $display("FAIL reset outputs n3 got %h exp 0",
        {b3.busy, b3.done, b3.f_valid, b3.vec_out, b3.f_out, b3.ones_count});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full sweep against the model table tt, optionally loading tt in the start cycle.
  task automatic test_sweep(input string name, input logic [15:0] tt, input bit load);
    int ones;
    logic [12:0] exp;
    @(negedge clk);
    bus.start = 1'b1;
    if (load) begin bus.tt_load = 1'b1; bus.tt_in = tt; end
    @(negedge clk);
    bus.start = 1'b0; bus.tt_load = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.f_valid !== 1'b0 || bus.ones_count !== 5'd0) begin
      errors++; $display("FAIL %s start got %h", name, obs());
    end
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ones += int'(tt[i]);
      exp = {1'b1, 1'b0, 1'b1, 4'(i), tt[i], 5'(ones)};
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL %s vec %0d got %h exp %h", name, i, obs(), exp);
      end
    end
    @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 4'd15, tt[15], 5'($countones(tt))};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL %s done got %h exp %h", name, obs(), exp);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s idle got %h", name, obs());
    end
  endtask

  task automatic test_ignored();
    logic [15:0] tt = 16'hDF03;
    int ones = 0;
    logic [12:0] exp;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.tt_load = 1'b0;
      ones += int'(tt[i]);
      exp = {1'b1, 1'b0, 1'b1, 4'(i), tt[i], 5'(ones)};
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL ignored vec %0d got %h exp %h", i, obs(), exp);
      end
      if (i == 5) begin bus.start = 1'b1; bus.tt_load = 1'b1; bus.tt_in = 16'hFFFF; end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.ones_count !== 5'd9) begin
      errors++; $display("FAIL ignored done got %h exp done=1 ones=9", obs());
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL ignored second_done cyc %0d got %h", c, obs());
      end
    end
    test_sweep("ignored_followup", 16'hDF03, 1'b0);
  endtask

`ifdef BOOLFN_SWEEP_STEP_EN
  task automatic test_stall();
    logic [15:0] tt = 16'hDF03;
    int ones = 0;
    int i = 0;
    int stall = 0;
    logic [12:0] exp;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    while (i < 16) begin
      @(negedge clk);
      if (stall > 0) begin
        exp = {1'b1, 1'b0, 1'b0, 4'd3, tt[3], 5'(ones)};
        stall--;
        if (stall == 0) bus.step = 1'b1;
      end else begin
        ones += int'(tt[i]);
        exp = {1'b1, 1'b0, 1'b1, 4'(i), tt[i], 5'(ones)};
        if (i == 3) begin bus.step = 1'b0; stall = 3; end
        i++;
      end
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL stall vec %0d got %h exp %h", i, obs(), exp);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.ones_count !== 5'd9) begin
      errors++; $display("FAIL stall done got %h exp done=1 ones=9", obs());
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] tt = 16'hFFFF;
    logic [12:0] exp;
    @(negedge clk); bus.tt_load = 1'b1; bus.tt_in = tt;
    @(negedge clk); bus.tt_load = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b1, 4'(i), 1'b1, 5'(i + 1)};
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL reset_mid vec %0d got %h exp %h", i, obs(), exp);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 13'h0) begin
      errors++; $display("FAIL reset_mid async got %h exp 0", obs());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++; $display("FAIL reset_mid no_done cyc %0d got %b exp 0", c, bus.done);
      end
    end
    test_sweep("reset_mid_followup", 16'hDF03, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] tt;
    bit load;
    for (int r = 0; r < 6; r++) begin
      tt   = 16'($urandom_range(0, 65535));
      load = 1'($urandom_range(0, 1));
      if (!load) begin
        @(negedge clk); bus.tt_load = 1'b1; bus.tt_in = tt;
        @(negedge clk); bus.tt_load = 1'b0;
      end
      test_sweep($sformatf("random%0d", r), tt, load);
    end
  endtask

  task automatic test_width();
    logic [10:0] got, exp;
    @(negedge clk); b3.start = 1'b1;
    @(negedge clk); b3.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got = {b3.busy, b3.done, b3.f_valid, b3.vec_out, b3.f_out, b3.ones_count};
      exp = {1'b1, 1'b0, 1'b1, 3'(i), 1'b1, 4'(i + 1)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL width vec %0d got %h exp %h", i, got, exp);
      end
    end
    @(negedge clk);
    got = {b3.busy, b3.done, b3.f_valid, b3.vec_out, b3.f_out, b3.ones_count};
    exp = {1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 4'b1000};
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL width done got %h exp %h", got, exp);
    end
  endtask

  initial begin
    bus.tt_load = 1'b0; bus.tt_in = '0; bus.start = 1'b0; bus.step = 1'b1;
    b3.tt_load  = 1'b0; b3.tt_in  = '0; b3.start  = 1'b0; b3.step  = 1'b1;
    test_reset();
    test_sweep("default", 16'hDF03, 1'b0);
    test_ignored();
`ifdef BOOLFN_SWEEP_STEP_EN
    test_stall();
`endif
    test_reset_mid();
    test_sweep("load_and_start", 16'h8001, 1'b1);
    test_random();
    test_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
